// File: rtl/fma_share_arb.sv
// fma_share_arb
//   Lets two requesters share one fixed-latency, fully pipelined FMA unit.
//   Requester 0 is the scalar FPU issue stage. Requester 1 is the divide/sqrt
//   iteration or a vector lane. Issue slots are granted round-robin. A tag
//   pipeline that runs alongside the unit records the owner of every
//   in-flight operation. Each result is steered into that owner's result FIFO.
//   Credits reserve FIFO space for every issued operation, so a result never
//   finds its FIFO full.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   Req0Valid/Ready/Op      requester 0 issue handshake and operand bundle
//   Req1Valid/Ready/Op      requester 1 issue handshake and operand bundle
//   UnitIssue, UnitOp       operation presented to the shared unit
//   UnitRes                 unit result, valid LAT cycles after UnitIssue
//   Res0Valid/Ready/Data    requester 0 result FIFO head
//   Res1Valid/Ready/Data    requester 1 result FIFO head
//   Flush0                  kill all requester-0 work (only when the
//                           FMA_SHARE_ARB_FLUSH_EN macro is defined)
//
// Optional feature macro: FMA_SHARE_ARB_FLUSH_EN

// Registered first-word-fall-through FIFO. The head entry is always visible
// on data. Requesting a pop while the FIFO is empty has no effect.
module fma_share_arb_fifo #(
  parameter int DW    = 72,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop_req,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop;

  assign valid = (count != '0);
  assign pop   = valid & pop_req;
  assign data  = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap on their own.
  // A push and a pop in the same cycle leave the count unchanged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Storage needs no reset. Only entries counted as valid are ever read.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

module fma_share_arb #(
  parameter int WIDTH  = 200,
  parameter int RWIDTH = 72,
  parameter int LAT    = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              Req0Valid,
  output logic              Req0Ready,
  input  logic [WIDTH-1:0]  Req0Op,
  input  logic              Req1Valid,
  output logic              Req1Ready,
  input  logic [WIDTH-1:0]  Req1Op,
  output logic              UnitIssue,
  output logic [WIDTH-1:0]  UnitOp,
  input  logic [RWIDTH-1:0] UnitRes,
  output logic              Res0Valid,
  input  logic              Res0Ready,
  output logic [RWIDTH-1:0] Res0Data,
  output logic              Res1Valid,
  input  logic              Res1Ready,
  output logic [RWIDTH-1:0] Res1Data
`ifdef FMA_SHARE_ARB_FLUSH_EN
  ,
  input  logic              Flush0
`endif
);

  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int SW   = $clog2(DEPTH + LAT + 1) + 1;

  logic            flush0;
  logic [LAT-1:0]  tag_v;
  logic [LAT-1:0]  tag_o;
  logic [LAT-1:0]  tag_live;
  logic [SW-1:0]   inflight0;
  logic [SW-1:0]   inflight1;
  logic [SW-1:0]   used0;
  logic [SW-1:0]   used1;
  logic [CNTW-1:0] cnt0;
  logic [CNTW-1:0] cnt1;
  logic            elig0;
  logic            elig1;
  logic            grant0;
  logic            grant1;
  logic            prefer_one;
  logic            push0;
  logic            push1;

`ifdef FMA_SHARE_ARB_FLUSH_EN
  assign flush0 = Flush0;
`else
  assign flush0 = 1'b0;
`endif

  // A flush drops every owner-0 tag right away. That includes the tag at the
  // output stage, so the result it would push this cycle is dropped.
  assign tag_live = flush0 ? (tag_v & tag_o) : tag_v;

  // Count the in-flight operations of each owner across all tag stages.
  always_comb begin
    inflight0 = '0;
    inflight1 = '0;
    for (int i = 0; i < LAT; i++) begin
      if (tag_v[i] && !tag_o[i]) inflight0 = inflight0 + SW'(1);
      if (tag_v[i] &&  tag_o[i]) inflight1 = inflight1 + SW'(1);
    end
  end

  // Credit is DEPTH minus (FIFO entries + in-flight ops). A requester is
  // eligible while the slots it already holds are fewer than DEPTH.
  // Both requesters are held off while reset is asserted.
  assign used0 = SW'(cnt0) + inflight0;
  assign used1 = SW'(cnt1) + inflight1;
  assign elig0 = reset_n & Req0Valid & (used0 < SW'(DEPTH)) & ~flush0;
  assign elig1 = reset_n & Req1Valid & (used1 < SW'(DEPTH));

  // Round-robin arbitration. prefer_one names the requester that wins a tie.
  // It points away from the requester that was granted last.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (elig0 && elig1) begin
      grant0 = ~prefer_one;
      grant1 =  prefer_one;
    end else begin
      grant0 = elig0;
      grant1 = elig1;
    end
  end

  assign Req0Ready = grant0;
  assign Req1Ready = grant1;
  assign UnitIssue = grant0 | grant1;

  // Operand steering to the unit. The bus is zero when nothing is granted.
  always_comb begin
    UnitOp = '0;
    if (grant0)      UnitOp = Req0Op;
    else if (grant1) UnitOp = Req1Op;
  end

  // The priority pointer moves only when a grant is given.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prefer_one <= 1'b0;
    end else if (grant0) begin
      prefer_one <= 1'b1;
    end else if (grant1) begin
      prefer_one <= 1'b0;
    end
  end

  // The tag pipeline shifts every cycle in step with the unit and never
  // stalls. Bit LAT-1 is the stage whose result is on UnitRes this cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_v <= '0;
      tag_o <= '0;
    end else begin
      tag_v <= (tag_live << 1) | LAT'(UnitIssue);
      tag_o <= (tag_o << 1)    | LAT'(grant1);
    end
  end

  assign push0 = tag_live[LAT-1] & ~tag_o[LAT-1];
  assign push1 = tag_live[LAT-1] &  tag_o[LAT-1];

  fma_share_arb_fifo #(
    .DW    (RWIDTH),
    .DEPTH (DEPTH),
    .CW    (CNTW)
  ) u_fifo0 (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (flush0),
    .push      (push0),
    .push_data (UnitRes),
    .pop_req   (Res0Ready),
    .valid     (Res0Valid),
    .data      (Res0Data),
    .count     (cnt0)
  );

  fma_share_arb_fifo #(
    .DW    (RWIDTH),
    .DEPTH (DEPTH),
    .CW    (CNTW)
  ) u_fifo1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (1'b0),
    .push      (push1),
    .push_data (UnitRes),
    .pop_req   (Res1Ready),
    .valid     (Res1Valid),
    .data      (Res1Data),
    .count     (cnt1)
  );

`ifndef SYNTHESIS
  // Credits reserve a FIFO slot for every in-flight op.
  // A push into a full FIFO therefore means the credit accounting is broken.
  a_no_push_full0: assert property (@(posedge clk) disable iff (!reset_n)
    !(push0 && (cnt0 == CNTW'(DEPTH))));
  a_no_push_full1: assert property (@(posedge clk) disable iff (!reset_n)
    !(push1 && (cnt1 == CNTW'(DEPTH))));
`endif

endmodule

// File: tb/tb_fma_share_arb.sv
// tb_fma_share_arb
//   Drives fma_share_arb with directed and random traffic and models the
//   shared unit as a LAT-deep pipeline. Each requester is tracked as a queue
//   of outstanding results. A queue entry holds the cycle its result should
//   become visible and the data it should carry.
//   Prints the line "CHECKS <n> ERRORS <m>" at the end.
//   Optional feature macro: FMA_SHARE_ARB_FLUSH_EN
module tb_fma_share_arb;

  localparam int WIDTH  = 200;
  localparam int RWIDTH = 72;
  localparam int LAT    = 4;
  localparam int DEPTH  = 4;

  typedef struct {
    int                ready_cyc;
    logic [RWIDTH-1:0] data;
  } res_t;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              Req0Valid, Req1Valid;
  logic              Req0Ready, Req1Ready;
  logic [WIDTH-1:0]  Req0Op, Req1Op;
  logic              UnitIssue;
  logic [WIDTH-1:0]  UnitOp;
  logic [RWIDTH-1:0] UnitRes;
  logic              Res0Valid, Res1Valid;
  logic              Res0Ready, Res1Ready;
  logic [RWIDTH-1:0] Res0Data, Res1Data;
`ifdef FMA_SHARE_ARB_FLUSH_EN
  logic              Flush0;
`endif

  res_t q0[$];
  res_t q1[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_grant = 1;

  logic [RWIDTH-1:0] unit_pipe [LAT];

  always #5 clk = ~clk;

  fma_share_arb #(
    .WIDTH  (WIDTH),
    .RWIDTH (RWIDTH),
    .LAT    (LAT),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .Req0Valid (Req0Valid),
    .Req0Ready (Req0Ready),
    .Req0Op    (Req0Op),
    .Req1Valid (Req1Valid),
    .Req1Ready (Req1Ready),
    .Req1Op    (Req1Op),
    .UnitIssue (UnitIssue),
    .UnitOp    (UnitOp),
    .UnitRes   (UnitRes),
    .Res0Valid (Res0Valid),
    .Res0Ready (Res0Ready),
    .Res0Data  (Res0Data),
    .Res1Valid (Res1Valid),
    .Res1Ready (Res1Ready),
    .Res1Data  (Res1Data)
`ifdef FMA_SHARE_ARB_FLUSH_EN
    ,
    .Flush0    (Flush0)
`endif
  );

  function automatic logic [WIDTH-1:0] rand_op();
    logic [223:0] t;
    for (int i = 0; i < 7; i++) t[i*32 +: 32] = $urandom();
    return t[WIDTH-1:0];
  endfunction

  function automatic logic [RWIDTH-1:0] rand_res();
    logic [95:0] t;
    for (int i = 0; i < 3; i++) t[i*32 +: 32] = $urandom();
    return t[RWIDTH-1:0];
  endfunction

  // The result the stand-in unit produces for an operand bundle.
  function automatic logic [RWIDTH-1:0] unit_f(input logic [WIDTH-1:0] op);
    return op[RWIDTH-1:0] ^ op[WIDTH-1 -: RWIDTH];
  endfunction

  // Stand-in FMA unit: an operation issued at one edge appears on UnitRes
  // LAT cycles later. Cycles with no issue carry random data, which the
  // DUT must never push into a FIFO.
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) unit_pipe[i] <= unit_pipe[i-1];
    unit_pipe[0] <= UnitIssue ? unit_f(UnitOp) : rand_res();
  end
  assign UnitRes = unit_pipe[LAT-1];

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                             input logic [WIDTH-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one clock cycle and checks the DUT outputs against the queue model.
  // The task returns while that cycle's outputs are still on the wires.
  task automatic applyStimulus(input bit rst, input bit v0, input bit v1,
                               input bit r0, input bit r1, input bit fl);
    logic [WIDTH-1:0] op0, op1, exp_op;
    bit   e0, e1, g0, g1, rv0, rv1;
    res_t item;
    @(negedge clk);
    op0       = rand_op();
    op1       = rand_op();
    reset_n   = !rst;
    Req0Valid = v0;
    Req1Valid = v1;
    Req0Op    = op0;
    Req1Op    = op1;
    Res0Ready = r0;
    Res1Ready = r1;
`ifdef FMA_SHARE_ARB_FLUSH_EN
    Flush0    = fl;
`endif
    #1;
    g0 = 0; g1 = 0; rv0 = 0; rv1 = 0;
    if (rst) begin
      q0.delete();
      q1.delete();
      last_grant = 1;
    end else begin
      e0 = v0 && (q0.size() < DEPTH) && !fl;
      e1 = v1 && (q1.size() < DEPTH);
      if (e0 && e1) begin
        g0 = (last_grant == 1);
        g1 = !g0;
      end else begin
        g0 = e0;
        g1 = e1;
      end
      if (q0.size() > 0) rv0 = (q0[0].ready_cyc <= cyc);
      if (q1.size() > 0) rv1 = (q1[0].ready_cyc <= cyc);
    end
    exp_op = g0 ? op0 : (g1 ? op1 : '0);
    checkOutput("req0_ready", WIDTH'(Req0Ready), WIDTH'(g0));
    checkOutput("req1_ready", WIDTH'(Req1Ready), WIDTH'(g1));
    checkOutput("unit_issue", WIDTH'(UnitIssue), WIDTH'(g0 | g1));
    checkOutput("unit_op", UnitOp, exp_op);
    checkOutput("res0_valid", WIDTH'(Res0Valid), WIDTH'(rv0));
    checkOutput("res1_valid", WIDTH'(Res1Valid), WIDTH'(rv1));
    if (rv0) checkOutput("res0_data", WIDTH'(Res0Data), WIDTH'(q0[0].data));
    if (rv1) checkOutput("res1_data", WIDTH'(Res1Data), WIDTH'(q1[0].data));
    if (!rst) begin
      if (fl) q0.delete();
      else if (rv0 && r0) void'(q0.pop_front());
      if (rv1 && r1) void'(q1.pop_front());
      if (g0) begin
        item.ready_cyc = cyc + LAT + 1;
        item.data      = unit_f(op0);
        q0.push_back(item);
        last_grant = 0;
      end
      if (g1) begin
        item.ready_cyc = cyc + LAT + 1;
        item.data      = unit_f(op1);
        q1.push_back(item);
        last_grant = 1;
      end
    end
    cyc++;
  endtask

  initial begin
    int issue_cyc, found, g0cnt, g1cnt, first_g0, resume_idx, vcnt, p0cnt, p1cnt;
    bit rr, fl;
    reset_n = 1'b0;
    Req0Valid = 1'b0; Req1Valid = 1'b0;
    Req0Op = '0; Req1Op = '0;
    Res0Ready = 1'b0; Res1Ready = 1'b0;
`ifdef FMA_SHARE_ARB_FLUSH_EN
    Flush0 = 1'b0;
`endif

    // Reset with both requests high: no grants, no results.
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 1, 1, 0);
    while (cyc < 10) applyStimulus(0, 0, 0, 1, 1, 0);

    // Single op issued at cycle 10 must be visible at 10+LAT+1.
    issue_cyc = cyc;
    applyStimulus(0, 1, 0, 1, 1, 0);
    checkOutput("single_issue", WIDTH'(UnitIssue), WIDTH'(1'b1));
    found = -1;
    for (int k = 0; k < 12; k++) begin
      applyStimulus(0, 0, 0, 1, 1, 0);
      if (Res0Valid && found < 0) found = cyc - 1;
    end
    checkOutput("single_latency", WIDTH'(found), WIDTH'(issue_cyc + LAT + 1));

    // Contention after reset: alternate starting with requester 0.
    for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, 1, 1, 0);
    g0cnt = 0; g1cnt = 0; first_g0 = 0;
    for (int k = 0; k < 16; k++) begin
      applyStimulus(0, 1, 1, 1, 1, 0);
      if (k == 0) first_g0 = int'(Req0Ready);
      g0cnt += int'(Req0Ready);
      g1cnt += int'(Req1Ready);
    end
    checkOutput("contention_first", WIDTH'(first_g0), WIDTH'(1));
    checkOutput("contention_g0", WIDTH'(g0cnt), WIDTH'(8));
    checkOutput("contention_g1", WIDTH'(g1cnt), WIDTH'(8));
    for (int k = 0; k < 12; k++) applyStimulus(0, 0, 0, 1, 1, 0);

    // Backpressure on requester 0: exactly DEPTH grants, then it stalls.
    g0cnt = 0;
    for (int k = 0; k < 14; k++) begin
      applyStimulus(0, 1, 1, 0, 1, 0);
      g0cnt += int'(Req0Ready);
    end
    checkOutput("backpressure_g0", WIDTH'(g0cnt), WIDTH'(DEPTH));
    resume_idx = -1;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 1, 1, 1, 1, 0);
      if (Req0Ready && resume_idx < 0) resume_idx = k;
    end
    checkOutput("backpressure_resume", WIDTH'(resume_idx), WIDTH'(1));

    // Steady requester-0 traffic with pushes and pops in the same cycle.
    for (int k = 0; k < 15; k++) applyStimulus(0, 1, 0, 1, 0, 0);
    for (int k = 0; k < 12; k++) applyStimulus(0, 0, 0, 1, 1, 0);

    // Reset with ops in flight: nothing is delivered and credits come back.
    for (int k = 0; k < 3; k++) applyStimulus(0, 1, 1, 1, 1, 0);
    applyStimulus(1, 0, 0, 1, 1, 0);
    vcnt = 0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(0, 0, 0, 1, 1, 0);
      vcnt += int'(Res0Valid) + int'(Res1Valid);
    end
    checkOutput("reset_no_results", WIDTH'(vcnt), WIDTH'(0));
    g0cnt = 0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(0, 1, 0, 0, 1, 0);
      g0cnt += int'(Req0Ready);
    end
    checkOutput("reset_credits", WIDTH'(g0cnt), WIDTH'(DEPTH));
    for (int k = 0; k < 12; k++) applyStimulus(0, 0, 0, 1, 1, 0);

`ifdef FMA_SHARE_ARB_FLUSH_EN
    // Two ops per requester in flight, then a flush of requester 0.
    for (int k = 0; k < 4; k++) applyStimulus(0, 1, 1, 1, 1, 0);
    p0cnt = 0; p1cnt = 0;
    applyStimulus(0, 1, 0, 1, 1, 1);
    p1cnt += int'(Res1Valid);
    applyStimulus(0, 1, 0, 1, 1, 0);
    checkOutput("flush_regrant", WIDTH'(Req0Ready), WIDTH'(1'b1));
    checkOutput("flush_fifo0_empty", WIDTH'(Res0Valid), WIDTH'(1'b0));
    p0cnt += int'(Res0Valid);
    p1cnt += int'(Res1Valid);
    for (int k = 0; k < 12; k++) begin
      applyStimulus(0, 0, 0, 1, 1, 0);
      p0cnt += int'(Res0Valid);
      p1cnt += int'(Res1Valid);
    end
    checkOutput("flush_res1_count", WIDTH'(p1cnt), WIDTH'(2));
    checkOutput("flush_res0_count", WIDTH'(p0cnt), WIDTH'(1));
`else
    p0cnt = 0; p1cnt = 0;
`endif

    // Random traffic with occasional resets (and flushes when present).
    for (int k = 0; k < 400; k++) begin
      rr = ($urandom_range(0, 149) == 0);
`ifdef FMA_SHARE_ARB_FLUSH_EN
      fl = ($urandom_range(0, 39) == 0);
`else
      fl = 1'b0;
`endif
      applyStimulus(rr, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7, fl);
    end
    for (int k = 0; k < 20; k++) applyStimulus(0, 0, 0, 1, 1, 0);
    checkOutput("final_q0_drained", WIDTH'(q0.size()), WIDTH'(0));
    checkOutput("final_q1_drained", WIDTH'(q1.size()), WIDTH'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
